ddr_filler: RTL

AXI4 write master that fills one DDR bank with a deterministic incrementing-word pattern before the bank is read back and timed. Sits directly upstream of the bank read-back stage on the same memory port. It shares that stage's geometry: burst length, burst count and base address. It measures its own fill time in clock cycles so write bandwidth can be reported alongside read bandwidth.

---
 rtl/ddr_filler_if.sv | 72 +++++++
 rtl/ddr_filler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_filler_if.sv
// AXI4 master bundle for the DDR fill engine: write channels active, read
// channels present so the port is complete but tied off by the master.
interface ddr_filler_if #(
  parameter int DW = 512
);
  logic [63:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [3:0]    awid;
  logic [1:0]    awburst;
  logic          awlock;
  logic [3:0]    awcache;
  logic [3:0]    awqos;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;

  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wlast;
  logic            wready;

  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  logic [63:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [3:0]    arid;
  logic [1:0]    arburst;
  logic          arlock;
  logic [3:0]    arcache;
  logic [3:0]    arqos;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;

  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awlen, awsize, awid, awburst, awlock, awcache, awqos, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arid, arburst, arlock, arcache, arqos, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awid, awburst, awlock, awcache, awqos, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arid, arburst, arlock, arcache, arqos, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ddr_filler.sv
// DDR bank fill master: writes an incrementing-word pattern over BURST_COUNT
// INCR bursts and counts the cycles the pass takes.
//
// state | meaning
// IDLE  | engine not issuing (no valid driven)
// SEND  | engine holds its VALID high until its last handshake

module cdc_single (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module ddr_filler #(
  parameter int          DW              = 512,
  parameter int          BEATS_PER_BURST = 64,
  parameter int          BURST_COUNT     = 1024,
  parameter logic [63:0] BASE_ADDR       = 64'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_async,
  output logic         idle,
  output logic [63:0]  elapsed,
  output logic         bresp_err,
  ddr_filler_if.master m_axi
);
  localparam int          LANES         = DW / 32;
  localparam int          BURST_BYTES   = BEATS_PER_BURST * DW / 8;
  localparam logic [63:0] ADDR_STEP     = 64'(BURST_BYTES);
  localparam logic [31:0] LAST_BURST    = 32'(BURST_COUNT - 1);
  localparam logic [31:0] LAST_BEAT     = 32'(BURST_COUNT * BEATS_PER_BURST - 1);
  localparam logic [7:0]  LAST_IN_BURST = 8'(BEATS_PER_BURST - 1);

  typedef enum logic {IDLE, SEND} eng_state_t;

  eng_state_t  aw_state, aw_next, w_state, w_next;
  logic        start_sync, start_d, accept, busy;
  logic        aw_hs, w_hs, b_hs, b_done;
  logic        awvalid_c, wvalid_c, wlast_c;
  logic [31:0] aw_left, w_left, b_left, beat_n;
  logic [7:0]  beat_in_burst;
  logic [63:0] awaddr_q;
  logic [DW-1:0] wdata_c;

  cdc_single u_start_sync (
    .clk   (clk),
    .reset (reset),
    .d     (start_async),
    .q     (start_sync)
  );

  assign accept = start_sync & ~start_d & ~busy;
  assign aw_hs  = awvalid_c & m_axi.awready;
  assign w_hs   = wvalid_c & m_axi.wready;
  assign b_hs   = busy & m_axi.bvalid & m_axi.bready;
  assign b_done = b_hs & (b_left == '0);
  assign idle   = ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_state <= IDLE;
      w_state  <= IDLE;
    end else begin
      aw_state <= aw_next;
      w_state  <= w_next;
    end
  end

  always_comb begin
    aw_next   = aw_state;
    w_next    = w_state;
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    wlast_c   = 1'b0;
    case (aw_state)
      IDLE: if (accept) aw_next = SEND;
      SEND: begin
        awvalid_c = 1'b1;
        if (aw_hs && aw_left == '0) aw_next = IDLE;
      end
      default: aw_next = IDLE;
    endcase
    case (w_state)
      IDLE: if (accept) w_next = SEND;
      SEND: begin
        wvalid_c = 1'b1;
        wlast_c  = (beat_in_burst == LAST_IN_BURST);
        if (w_hs && w_left == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counters are down-counters to the terminal handshake; beat_n only ever counts up
  // because it also seeds the data pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d       <= 1'b0;
      busy          <= 1'b0;
      elapsed       <= '0;
      bresp_err     <= 1'b0;
      aw_left       <= '0;
      w_left        <= '0;
      b_left        <= '0;
      beat_n        <= '0;
      beat_in_burst <= '0;
      awaddr_q      <= BASE_ADDR;
    end else begin
      start_d <= start_sync;
      if (accept) begin
        busy          <= 1'b1;
        elapsed       <= '0;
        bresp_err     <= 1'b0;
        aw_left       <= LAST_BURST;
        w_left        <= LAST_BEAT;
        b_left        <= LAST_BURST;
        beat_n        <= '0;
        beat_in_burst <= '0;
        awaddr_q      <= BASE_ADDR;
      end else begin
        if (busy) elapsed <= elapsed + 64'd1;
        if (b_done) busy <= 1'b0;
        if (aw_hs) begin
          awaddr_q <= awaddr_q + ADDR_STEP;
          if (aw_left != '0) aw_left <= aw_left - 32'd1;
        end
        if (w_hs) begin
          beat_n        <= beat_n + 32'd1;
          beat_in_burst <= wlast_c ? 8'd0 : beat_in_burst + 8'd1;
          if (w_left != '0) w_left <= w_left - 32'd1;
        end
        if (b_hs) begin
          if (b_left != '0) b_left <= b_left - 32'd1;
          if (m_axi.bresp != 2'b00) bresp_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata_c[32*i +: 32] = beat_n * 32'(LANES) + 32'(i);
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = LAST_IN_BURST;
  assign m_axi.awsize  = 3'($clog2(DW / 8));
  assign m_axi.awid    = 4'd0;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd2;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awprot  = 3'd2;
  assign m_axi.awvalid = awvalid_c;
  assign m_axi.wdata   = wdata_c;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_c;
  assign m_axi.wlast   = wlast_c;
  assign m_axi.bready  = 1'b1;

  assign m_axi.araddr  = '0;
  assign m_axi.arlen   = '0;
  assign m_axi.arsize  = '0;
  assign m_axi.arid    = '0;
  assign m_axi.arburst = '0;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = '0;
  assign m_axi.arqos   = '0;
  assign m_axi.arprot  = '0;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, m_axi.arready, m_axi.rid, m_axi.rdata, m_axi.rresp,
                       m_axi.rlast, m_axi.rvalid};
endmodule
